// File: rtl/axi_lite_mem_responder.sv
// axi_lite_mem_responder: AXI4-Lite slave backed by a byte-strobed register-array memory
// Ports: ACLK/ARESET (sync, active-high); S_AXI_AW*/W*/B* write channels; S_AXI_AR*/R* read
// channels; err_count = saturating count of SLVERR responses issued.
`timescale 1ns/1ps
module axi_lite_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [7:0]              err_count
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int SW = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]         w_strb;
  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [8:0]            err_sum;
  logic                  unused_ok;
  // Readies depend only on state (and reset), never on a VALID input.
  assign S_AXI_AWREADY = !ARESET && !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !ARESET && !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;
  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  // A held half pairs with the other half arriving live, or both arrive together.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? aw_addr : S_AXI_AWADDR;
  assign wr_data = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
  assign wr_ok   = wr_addr[ADDR_WIDTH-1:IW+2] == '0;
  assign rd_ok   = S_AXI_ARADDR[ADDR_WIDTH-1:IW+2] == '0;
  assign wr_idx  = wr_addr[IW+1:2];
  assign rd_idx  = S_AXI_ARADDR[IW+1:2];
  assign err_sum = {1'b0, err_count} + 9'(commit && !wr_ok) + 9'(ar_hs && !rd_ok);
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= 2'b00;
      err_count    <= 8'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
        for (int b = 0; b < SW; b++)
          if (wr_ok && wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_addr <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= S_AXI_WDATA;
          w_strb <= S_AXI_WSTRB;
        end
        if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      end
      // The array read sees pre-edge contents, so a same-edge write returns old data.
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_ok ? mem[rd_idx] : '0;
        S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
      err_count <= err_sum > 9'd255 ? 8'hFF : err_sum[7:0];
    end
  end
endmodule

// File: doc/axi_lite_mem_responder.md
# axi_lite_mem_responder

AXI4-Lite slave that terminates transactions from the accelerator's AXI4-Lite masters (the `data` initiator and the BFM master used in the block design bench) and backs them with a small register-array memory. It accepts writes with byte strobes and reads back stored words. Out-of-range accesses return SLVERR. It closes the loop so the master-side INIT_AXI_TXN / TXN_DONE / ERROR sequence runs against a known, checkable target.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: data width; fixed at 32, giving 4 strobe bits.
- DEPTH_WORDS, 16: number of 32-bit words; must be a power of two, ≥ 2.
- ACLK  in  1  sole clock; all logic is on the rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  accepted and ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  OKAY = 2'b00, SLVERR = 2'b10.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  accepted and ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  OKAY / SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- err_count  out  8  saturating count of SLVERR responses issued.

## Operation
- **Address decode**
  - Word index = ADDR[log2(DEPTH_WORDS)+1:2].
  - The access is in range if ADDR[ADDR_WIDTH-1:log2(DEPTH_WORDS)+2] == 0. Otherwise SLVERR is returned, with no write and RDATA = 0.
  - ADDR[1:0] is ignored.
- **Write path**
  - The AW and W channels are captured independently into holding registers (aw_held, w_held). Arrival order is free; same-cycle arrival is allowed.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - Commit happens on the edge where an address is available (held or handshaking) and data is available (held or handshaking). On that edge:
    - In-range words are updated byte-wise per WSTRB.
    - BVALID is set, with BRESP per decode.
    - Both held flags are cleared.
  - BVALID holds with stable BRESP until BREADY. Only one write is outstanding at a time.
- **Read path**
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA/RRESP are registered from the array contents before the edge, and RVALID is set.
  - RVALID/RDATA/RRESP stay stable until RREADY. One read is outstanding at a time.
- **Read/write independence**
  - The read and write paths run concurrently.
  - If a read samples the same word on the same edge as a write commit, it returns the old data.
- **Error counter**
  - err_count increments on each edge that sets BVALID or RVALID with SLVERR. If both occur on the same edge, it increments by 2.
  - It saturates at 255.

## Timing
- **Reset values**
  - All READY outputs read 0 during reset and become 1 on the first cycle after ARESET deasserts.
  - BVALID = 0, RVALID = 0, BRESP = 0, RRESP = 0, RDATA = 0, err_count = 0, held flags = 0.
  - Memory is cleared to 0.
- **Write latency**
  - AW and W on the same cycle N: BVALID is high in cycle N+1.
  - AW in cycle N, W in cycle N+k: BVALID is high in cycle N+k+1.
- **Read latency**
  - AR handshake in cycle N: RVALID is high in cycle N+1.
  - With RREADY held high, the next AR can be accepted in cycle N+2, giving 1 read per 2 cycles.
- **Write throughput:** with BREADY held high, 1 write per 2 cycles.
- **Ready independence:** no combinational path from any VALID input to any READY output.
- **Reset mid-transaction:** any held AW/W and any pending B/R is discarded. No response is issued for it.

## Test plan
- **Basic write/read:** Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to addresses 0x0, 0x4, 0x8, 0xC, then read each back. Required: BRESP = 0, RRESP = 0, and RDATA equals the written data on every read.
- **Byte strobes:** Write 0xFFFFFFFF to 0x0, then write 0x12345678 to 0x0 with WSTRB = 4'b0101. A read of 0x0 must return 0xFF34FF78.
- **Channel ordering:** Present W at 0x4 three cycles before AW, then repeat with AW first.
  - Both cases: BVALID is asserted exactly 1 cycle after the later handshake, and readback is correct.
  - While W is held, WREADY = 0.
- **Out-of-range access:** Write and read at 0x40 (DEPTH_WORDS = 16).
  - Both responses are SLVERR, and RDATA = 0.
  - Word 0 is unchanged.
  - err_count = 2.
- **Back-pressure:** Hold BREADY and RREADY low for 5 cycles.
  - BVALID, RVALID, RDATA and RRESP stay stable for all 5 cycles.
  - AWREADY, WREADY and ARREADY stay 0 until the response handshake completes.
- **Reset mid-operation:** Assert ARESET for 1 cycle while AW is held and RVALID is pending.
  - Next cycle: BVALID = 0, RVALID = 0, err_count = 0, and all READY outputs = 1.
  - A subsequent read of 0x0 returns 0.
